mips_int_ctrl: RTL
==================

Name: mips_int_ctrl

Overview:
Interrupt controller that sits directly upstream of the MIPS core (mips_top) and drives its 5-bit INT input. It synchronizes asynchronous peripheral request lines, detects rising edges, latches them as pending, applies a software mask and fixed priority, and presents one interrupt at a time to the core. A two-pulse handshake (acknowledge on exception entry, done on ERET) retires each interrupt.

Parameters:
N_SRC, 5, number of interrupt sources; fixed to match core INT width.
SYNC_STAGES, 2, flip-flop depth of input synchronizer (min 2).
MASK_RST, 5'b11111, mask register value after reset (1 = enabled).

Ports:
clk  in  1  system clock, rising-edge.
rst  in  1  synchronous, active-low reset (0 = reset).
irq_src  in  N_SRC  async peripheral request lines, level; rising edge = request.
mask_we  in  1  load mask register from mask_wd this cycle.
mask_wd  in  N_SRC  mask write data.
mask_rd  out  N_SRC  current mask register.
pend_rd  out  N_SRC  current pending register.
int_ack  in  1  one-cycle pulse from core: exception entry taken.
int_done  in  1  one-cycle pulse from core: ERET executed.
INT  out  N_SRC  one-hot registered request to core INT input.
irq_id  out  3  index of granted source; valid while busy=1.
busy  out  1  1 in ASSERT or SERVICE.

Behaviour:
- Reset (rst=0 at clk edge): sync chain, edge-delay reg, pending=0, mask=MASK_RST, INT=0, irq_id=0, busy=0, state=IDLE. Reset mid-handshake abandons it; no pending survives.
- Sync regs reset to 0: a source held high across reset release counts as one rising edge.
- Edge detect: edge[i] = sync_out[i] & ~sync_dly[i]. Level held high produces exactly one request.
- Pending: pend[i] set on edge[i]; cleared on int_ack when i == granted index. Set and clear same cycle on same bit -> set wins (bit stays 1).
- Latency: irq_src rising just before edge 0 -> sync at edges 0,1 -> pend set at edge 2 -> INT asserted at edge 3 (if IDLE, unmasked, highest priority).
- Eligible = pend & mask. Priority fixed: lowest index wins.
- mask_we: mask <= mask_wd at clock edge. Masked pending bits remain latched and fire when unmasked.
- FSM:
  IDLE: busy=0, INT=0. If eligible != 0 -> ASSERT; latch irq_id = priority winner; INT <= one-hot(winner).
  ASSERT: INT held, busy=1. int_ack -> clear pend[irq_id], INT <= 0, -> SERVICE. Else if mask[irq_id] becomes 0 (including same-cycle mask_we) -> INT <= 0, -> IDLE, pending kept. Higher-priority arrivals do not preempt the grant.
  SERVICE: INT=0, busy=1, irq_id held. int_done -> IDLE. New edges only set pending.
- int_ack outside ASSERT and int_done outside SERVICE are ignored. int_ack and int_done in the same cycle: only the one valid for the current state acts.
- Back-to-back: from IDLE after int_done, next eligible source asserts INT on the following edge (1-cycle gap minimum).
- mask_rd/pend_rd are direct register outputs, no latency beyond the register.

Test Plan:
1. Reset, mask=5'h1F; pulse irq_src[3] high 3 cycles -> INT=5'b01000 exactly 4 edges after the rise, irq_id=3, busy=1; int_ack -> INT=0 next edge, pend_rd=0; int_done -> busy=0.
2. irq_src[1] and [4] rise together -> INT=5'b00010 first; after ack+done, INT=5'b10000 one edge after IDLE.
3. mask=5'b10111, pulse irq_src[3] -> pend_rd=5'b01000, INT stays 0; write mask=5'h1F -> INT=5'b01000 one edge later.
4. In ASSERT on source 2, write mask bit2=0 -> INT=0 next edge, state IDLE, pend_rd[2]=1; no spurious ack accepted.
5. New edge on source 0 in the same cycle as int_ack for source 0 -> pend_rd[0] stays 1; after int_done INT=5'b00001 again.
6. Assert rst=0 while in SERVICE with pending 5'b00110 -> next edge INT=0, busy=0, pend_rd=0, mask_rd=5'h1F; irq_src[2] held high through release -> one request, INT=5'b00100.

Source files
------------

// File: rtl/mips_int_ctrl.sv
// mips_int_ctrl
//   Interrupt controller feeding the 5-bit INT input of the MIPS core.
//   Asynchronous peripheral request lines are synchronized, rising edges are
//   latched as pending, a software mask and fixed lowest-index-wins priority
//   pick one source, and that source is presented one-hot on INT until the
//   core acknowledges it (int_ack) and later retires it (int_done).
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-low reset (0 = reset)
//   irq_src   asynchronous peripheral request lines, rising edge = request
//   mask_we   load mask register from mask_wd on this edge
//   mask_wd   mask write data (1 = source enabled)
//   mask_rd   current mask register
//   pend_rd   current pending register
//   int_ack   one-cycle pulse: core took the exception
//   int_done  one-cycle pulse: core executed ERET
//   INT       one-hot registered request to the core
//   irq_id    index of the granted source, meaningful while busy is high
//   busy      high while a grant is being presented or serviced

module mips_int_ctrl #(
  parameter int               N_SRC       = 5,
  parameter int               SYNC_STAGES = 2,
  parameter logic [N_SRC-1:0] MASK_RST    = 5'b11111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wd,
  output logic [N_SRC-1:0] mask_rd,
  output logic [N_SRC-1:0] pend_rd,
  input  logic             int_ack,
  input  logic             int_done,
  output logic [N_SRC-1:0] INT,
  output logic [2:0]       irq_id,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    SERVICE
  } state_t;

  state_t           state_q, state_n;
  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] sync_dly_q;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pend_q, pend_n, pend_clr;
  logic [N_SRC-1:0] mask_q, mask_n;
  logic [N_SRC-1:0] int_q, int_n;
  logic [N_SRC-1:0] eligible;
  logic [2:0]       id_q, id_n, winner;

  // Synchronizer chain plus one extra delay stage for edge detection.
  // Everything clears to zero on reset, so a line already high when reset
  // is released is seen as a single fresh rising edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      sync_dly_q <= '0;
    end else begin
      sync_q[0] <= irq_src;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      sync_dly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise     = sync_q[SYNC_STAGES-1] & ~sync_dly_q;
  assign mask_n   = mask_we ? mask_wd : mask_q;
  assign eligible = pend_q & mask_q;

  // Fixed priority: scanning from the top down leaves the lowest set index.
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = 3'(i);
      end
    end
  end

  // Grant FSM next-state logic. The mask check in ASSERT looks at the mask
  // value being written this cycle, so a same-cycle mask write withdraws the
  // grant immediately. A grant, once made, is never preempted by a
  // higher-priority arrival.
  always_comb begin
    state_n  = state_q;
    int_n    = int_q;
    id_n     = id_q;
    pend_clr = '0;
    case (state_q)
      IDLE: begin
        if (eligible != '0) begin
          state_n = ASSERT;
          id_n    = winner;
          int_n   = {{(N_SRC-1){1'b0}}, 1'b1} << winner;
        end
      end
      ASSERT: begin
        if (int_ack) begin
          pend_clr[id_q] = 1'b1;
          int_n          = '0;
          state_n        = SERVICE;
        end else if (!mask_n[id_q]) begin
          int_n   = '0;
          state_n = IDLE;
        end
      end
      SERVICE: begin
        if (int_done) begin
          state_n = IDLE;
        end
      end
      default: begin
        int_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // New rising edges are OR-ed in after the acknowledge clear, so an edge
  // arriving on the very bit being acknowledged survives as a new request.
  assign pend_n = (pend_q & ~pend_clr) | rise;

  // Register bank: state, pending, mask, INT and granted index.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      mask_q  <= MASK_RST;
      int_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_n;
      pend_q  <= pend_n;
      mask_q  <= mask_n;
      int_q   <= int_n;
      id_q    <= id_n;
    end
  end

  assign mask_rd = mask_q;
  assign pend_rd = pend_q;
  assign INT     = int_q;
  assign irq_id  = id_q;
  assign busy    = (state_q != IDLE);

endmodule
